// File: rtl/skein_block_loader_ctrl_if.sv
// rtl/skein_block_loader_ctrl_if.sv - message stream, buffer write port and block handoff bundle
interface skein_block_loader_ctrl_if #(
    parameter int WORD_W = 64
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [2*WORD_W-1:0]   in_data_i;
    logic                  in_pair_i;
    logic                  in_last_i;
    logic [1:0]            wr_en_o;
    logic [3:0]            wr_addr_o;
    logic [2*WORD_W-1:0]   wr_data_o;
    logic                  blk_valid_o;
    logic                  blk_ready_i;
    logic                  blk_last_o;
    logic [4:0]            blk_words_o;
    logic [31:0]           msg_words_o;
    logic                  busy_o;

    modport slave (
        input  in_valid_i, in_data_i, in_pair_i, in_last_i, blk_ready_i,
        output in_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               blk_valid_o, blk_last_o, blk_words_o, msg_words_o, busy_o
    );

    modport master (
        output in_valid_i, in_data_i, in_pair_i, in_last_i, blk_ready_i,
        input  in_ready_o, wr_en_o, wr_addr_o, wr_data_o,
               blk_valid_o, blk_last_o, blk_words_o, msg_words_o, busy_o
    );
endinterface

// File: rtl/skein_block_loader_ctrl.sv
// rtl/skein_block_loader_ctrl.sv - packs 64-bit message words into zero-padded 16-word Skein blocks
module skein_block_loader_ctrl #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int WORD_W          = 64
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    skein_block_loader_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {FILL, SPLIT, PAD, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          wr_en_q, wr_en_d;
    logic [CNT_W-1:0]    wr_addr_q, wr_addr_d;
    logic [2*WORD_W-1:0] wr_data_q, wr_data_d;
    logic                blk_valid_q, blk_valid_d;
    logic                blk_last_q, blk_last_d;
    logic [CNT_W:0]      blk_words_q, blk_words_d;
    logic [31:0]         msg_words_q, msg_words_d;
    logic [WORD_W-1:0]   held_q, held_d;
    logic                split_q, split_d;
    logic                last_q, last_d;
    // set once a final block is handed off; the next accepted beat restarts the message count
    logic                msg_done_q, msg_done_d;

    logic                cnt_clr, cnt_inc1, cnt_inc2;
    logic [1:0]          words;
    logic [CNT_W:0]      blk_fill;
    logic                split_beat;

    // state and datapath registers, cleared asynchronously so a reset aborts any block in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            wr_en_q     <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_words_q <= '0;
            msg_words_q <= '0;
            held_q      <= '0;
            split_q     <= 1'b0;
            last_q      <= 1'b0;
            msg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
            blk_words_q <= blk_words_d;
            msg_words_q <= msg_words_d;
            held_q      <= held_d;
            split_q     <= split_d;
            last_q      <= last_d;
            msg_done_q  <= msg_done_d;
        end
    end

    // next-state, write-port and block-handoff decisions; counter stepped via clr/+1/+2 controls
    always_comb begin
        state_d     = state_q;
        cnt_clr     = 1'b0;
        cnt_inc1    = 1'b0;
        cnt_inc2    = 1'b0;
        wr_en_d     = 2'b00;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        blk_words_d = blk_words_q;
        msg_words_d = msg_words_q;
        held_d      = held_q;
        split_d     = split_q;
        last_d      = last_q;
        msg_done_d  = msg_done_q;
        words       = 2'd0;
        blk_fill    = '0;
        split_beat  = 1'b0;

        case (state_q)
            FILL: begin
                if (bus.in_valid_i) begin
                    wr_addr_d = cnt_q;
                    if (!bus.in_pair_i) begin
                        wr_en_d   = 2'b01;
                        wr_data_d = {{WORD_W{1'b0}}, bus.in_data_i[WORD_W-1:0]};
                        cnt_inc1  = 1'b1;
                        words     = 2'd1;
                    end else if (cnt_q != '1) begin
                        wr_en_d   = 2'b11;
                        wr_data_d = bus.in_data_i;
                        cnt_inc2  = 1'b1;
                        words     = 2'd2;
                    end else begin
                        // second word overflows the block; park it for the next one
                        split_beat = 1'b1;
                        wr_en_d    = 2'b01;
                        wr_data_d  = {{WORD_W{1'b0}}, bus.in_data_i[WORD_W-1:0]};
                        held_d     = bus.in_data_i[2*WORD_W-1:WORD_W];
                        split_d    = 1'b1;
                        last_d     = bus.in_last_i;
                        cnt_inc1   = 1'b1;
                        words      = 2'd1;
                    end
                    blk_fill    = {1'b0, cnt_q} + (CNT_W+1)'(words);
                    blk_words_d = blk_fill;
                    msg_words_d = (msg_done_q ? 32'd0 : msg_words_q)
                                + (bus.in_pair_i ? 32'd2 : 32'd1);
                    msg_done_d  = 1'b0;
                    if (blk_fill[CNT_W]) begin
                        state_d     = ISSUE;
                        blk_valid_d = 1'b1;
                        blk_last_d  = bus.in_last_i && !split_beat;
                    end else if (bus.in_last_i) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                wr_addr_d = cnt_q;
                wr_data_d = '0;
                if (cnt_q[0]) begin
                    wr_en_d  = 2'b01;
                    cnt_inc1 = 1'b1;
                    words    = 2'd1;
                end else begin
                    wr_en_d  = 2'b11;
                    cnt_inc2 = 1'b1;
                    words    = 2'd2;
                end
                blk_fill = {1'b0, cnt_q} + (CNT_W+1)'(words);
                if (blk_fill[CNT_W]) begin
                    state_d     = ISSUE;
                    blk_valid_d = 1'b1;
                    blk_last_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.blk_ready_i) begin
                    cnt_clr     = 1'b1;
                    blk_valid_d = 1'b0;
                    blk_last_d  = 1'b0;
                    if (blk_last_q) msg_done_d = 1'b1;
                    state_d = split_q ? SPLIT : FILL;
                end
            end
            SPLIT: begin
                wr_en_d     = 2'b01;
                wr_addr_d   = '0;
                wr_data_d   = {{WORD_W{1'b0}}, held_q};
                cnt_inc1    = 1'b1;
                blk_words_d = (CNT_W+1)'(1);
                split_d     = 1'b0;
                last_d      = 1'b0;
                state_d     = last_q ? PAD : FILL;
            end
            default: state_d = FILL;
        endcase

        if (cnt_clr)       cnt_d = '0;
        else if (cnt_inc1) cnt_d = cnt_q + CNT_W'(1);
        else if (cnt_inc2) cnt_d = cnt_q + CNT_W'(2);
        else               cnt_d = cnt_q;
    end

    assign bus.in_ready_o  = (state_q == FILL);
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.blk_valid_o = blk_valid_q;
    assign bus.blk_last_o  = blk_last_q;
    assign bus.blk_words_o = blk_words_q;
    assign bus.msg_words_o = msg_words_q;
    assign bus.busy_o      = (state_q != FILL) || (cnt_q != '0);
endmodule

// File: tb/tb_skein_block_loader_ctrl.sv
// tb/tb_skein_block_loader_ctrl.sv - scoreboard bench for the Skein block loader
module tb_skein_block_loader_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [133:0] wq[$];
    logic [37:0]  bq[$];

    skein_block_loader_ctrl_if #(.WORD_W(64)) bus ();

    skein_block_loader_ctrl #(.WORDS_PER_BLOCK(16), .WORD_W(64)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] w(input int t, input int k);
        return {8'(t), 48'h0, 8'(k)};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_w(input logic [1:0] en, input int a, input logic [127:0] d);
        wq.push_back({en, 4'(a), d});
    endtask

    task automatic push_pad(input int start);
        int a = start;
        while (a < 16) begin
            if (a % 2 == 1) begin push_w(2'b01, a, 128'h0); a += 1; end
            else begin push_w(2'b11, a, 128'h0); a += 2; end
        end
    endtask

    task automatic send(input logic pair, input logic last, input logic [127:0] d);
        int n = 0;
        bus.in_valid_i = 1'b1;
        bus.in_pair_i  = pair;
        bus.in_last_i  = last;
        bus.in_data_i  = d;
        while (!bus.in_ready_o && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=not_ready expected=ready");
        end
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        bus.in_pair_i  = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((bus.busy_o || bus.blk_valid_o) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_within_budget", 160'(n < 500), 160'(1));
    endtask

    // monitor: compares every buffer write and every block handoff against the scoreboard
    initial begin
        logic [133:0] ew;
        logic [37:0]  eb;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wr_en_o != 2'b00) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wr_unexpected actual=%0h expected=none",
                             {bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o});
                end else begin
                    ew = wq.pop_front();
                    chk("wr", 160'({bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o}), 160'(ew));
                end
            end
            if (rst_n && bus.blk_valid_o && bus.blk_ready_i) begin
                if (bq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL blk_unexpected actual=%0h expected=none",
                             {bus.blk_last_o, bus.blk_words_o, bus.msg_words_o});
                end else begin
                    eb = bq.pop_front();
                    chk("blk", 160'({bus.blk_last_o, bus.blk_words_o, bus.msg_words_o}), 160'(eb));
                end
            end
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_pair_i   = 1'b0;
        bus.in_last_i   = 1'b0;
        bus.in_data_i   = '0;
        bus.blk_ready_i = 1'b1;
        #2;
        chk("rst_wr_en",     160'(bus.wr_en_o),     160'(0));
        chk("rst_blk_valid", 160'(bus.blk_valid_o), 160'(0));
        chk("rst_msg_words", 160'(bus.msg_words_o), 160'(0));
        chk("rst_busy",      160'(bus.busy_o),      160'(0));
        chk("rst_in_ready",  160'(bus.in_ready_o),  160'(1));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // 8 pair beats exactly filling a final block
        for (int i = 0; i < 8; i++) push_w(2'b11, 2*i, {w(1, 2*i+1), w(1, 2*i)});
        bq.push_back({1'b1, 5'd16, 32'd16});
        for (int i = 0; i < 8; i++) send(1'b1, i == 7, {w(1, 2*i+1), w(1, 2*i)});
        wait_idle();

        // 3 single beats, then zero pad from word 3
        for (int i = 0; i < 3; i++) push_w(2'b01, i, {64'h0, w(2, i)});
        push_pad(3);
        bq.push_back({1'b1, 5'd3, 32'd3});
        for (int i = 0; i < 3; i++) send(1'b0, i == 2, {64'h0, w(2, i)});
        wait_idle();

        // 15 singles then a pair at word 15: overflow word carried into a second block
        for (int i = 0; i < 15; i++) push_w(2'b01, i, {64'h0, w(3, i)});
        push_w(2'b01, 15, {64'h0, w(3, 15)});
        push_w(2'b01, 0, {64'h0, w(3, 16)});
        push_pad(1);
        bq.push_back({1'b0, 5'd16, 32'd17});
        bq.push_back({1'b1, 5'd1, 32'd17});
        for (int i = 0; i < 15; i++) send(1'b0, 1'b0, {64'h0, w(3, i)});
        send(1'b1, 1'b1, {w(3, 16), w(3, 15)});
        wait_idle();

        // full non-final block with the round core stalling
        bus.blk_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) push_w(2'b11, 2*i, {w(4, 2*i+1), w(4, 2*i)});
        bq.push_back({1'b0, 5'd16, 32'd16});
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, {w(4, 2*i+1), w(4, 2*i)});
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_valid",    160'(bus.blk_valid_o), 160'(1));
            chk("stall_in_ready", 160'(bus.in_ready_o),  160'(0));
            chk("stall_wr_en",    160'(bus.wr_en_o),     160'(0));
            chk("stall_words",    160'(bus.blk_words_o), 160'(16));
            chk("stall_last",     160'(bus.blk_last_o),  160'(0));
        end
        @(posedge clk); #1;
        bus.blk_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("post_hs_busy",  160'(bus.busy_o),      160'(0));
        chk("post_hs_valid", 160'(bus.blk_valid_o), 160'(0));

        // message continues; reset lands in PAD at word 6 before any pad write
        push_w(2'b11, 0, {w(5, 1), w(5, 0)});
        push_w(2'b11, 2, {w(5, 3), w(5, 2)});
        for (int i = 0; i < 3; i++) send(1'b1, i == 2, {w(5, 2*i+1), w(5, 2*i)});
        chk("pad_msg_words", 160'(bus.msg_words_o), 160'(22));
        chk("pad_in_ready",  160'(bus.in_ready_o),  160'(0));
        rst_n = 1'b0;
        #1;
        chk("arst_wr_en",     160'(bus.wr_en_o),     160'(0));
        chk("arst_wr_addr",   160'(bus.wr_addr_o),   160'(0));
        chk("arst_wr_data",   160'(bus.wr_data_o),   160'(0));
        chk("arst_blk_valid", 160'(bus.blk_valid_o), 160'(0));
        chk("arst_blk_last",  160'(bus.blk_last_o),  160'(0));
        chk("arst_blk_words", 160'(bus.blk_words_o), 160'(0));
        chk("arst_msg_words", 160'(bus.msg_words_o), 160'(0));
        chk("arst_busy",      160'(bus.busy_o),      160'(0));
        chk("arst_in_ready",  160'(bus.in_ready_o),  160'(1));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push_w(2'b01, 0, {64'h0, w(6, 0)});
        send(1'b0, 1'b0, {64'h0, w(6, 0)});
        chk("after_rst_msg_words", 160'(bus.msg_words_o), 160'(1));
        @(negedge clk);
        @(posedge clk); #1;
        chk("wr_queue_drained",  160'(wq.size()), 160'(0));
        chk("blk_queue_drained", 160'(bq.size()), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
